// File: rtl/key_event_queue.sv
// Classifies debounced key presses as single or double using a programmable
// window, and queues the classified events in a small FWFT FIFO with a valid/ready read port.
module key_event_queue #(
    parameter int unsigned KEY_WIDTH  = 2,
    parameter int unsigned DOUBLE_WIN = 25_000_000,
    parameter int unsigned CNT_W      = 25,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_flag,
    input  logic [KEY_WIDTH-1:0]          key_value,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [KEY_WIDTH-1:0]          evt_key,
    output logic                          evt_double,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTR_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(DOUBLE_WIN - 1);
    localparam logic [CNTR_W-1:0] FULL_CNT   = CNTR_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state;
    logic [CNT_W-1:0]     timer;
    logic [KEY_WIDTH-1:0] pend;

    logic strobe_c;
    logic match_c;
    logic push_c;
    logic push_dbl_c;
    logic pop_c;
    logic full_c;
    logic accept_c;

    logic [KEY_WIDTH-1:0] mem_key [FIFO_DEPTH];
    logic                 mem_dbl [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;

    assign strobe_c = key_flag && (key_value != '0);
    assign match_c  = (key_value == pend);

    // Event generation: a strobe in WAIT closes the pending press; otherwise expiry does.
    always_comb begin
        push_c     = 1'b0;
        push_dbl_c = 1'b0;
        if (state == WAIT) begin
            if (strobe_c) begin
                push_c     = 1'b1;
                push_dbl_c = match_c;
            end else if (timer == TIMER_LAST) begin
                push_c = 1'b1;
            end
        end
    end

    // Press classifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            pend  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe_c) begin
                        pend  <= key_value;
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (strobe_c) begin
                        if (match_c) begin
                            state <= IDLE;
                        end else begin
                            pend  <= key_value;
                            timer <= '0;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign evt_valid = (evt_count != '0);
    assign pop_c     = evt_valid && evt_ready;
    assign full_c    = (evt_count == FULL_CNT);
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign accept_c  = push_c && (!full_c || pop_c);

    assign evt_key    = mem_key[rd_ptr];
    assign evt_double = mem_dbl[rd_ptr];

    // Event FIFO; storage is reset so the head outputs are never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_key[i] <= '0;
                mem_dbl[i] <= 1'b0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= push_c && full_c && !pop_c;
            if (accept_c) begin
                mem_key[wr_ptr] <= pend;
                mem_dbl[wr_ptr] <= push_dbl_c;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept_c && !pop_c) begin
                evt_count <= evt_count + CNTR_W'(1);
            end else if (pop_c && !accept_c) begin
                evt_count <= evt_count - CNTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed and random press/drain traffic compared
// every cycle against a timestamp-based press classifier and an event queue model.
module tb_key_event_queue;

    localparam int KW   = 2;
    localparam int DW   = 16;
    localparam int CW   = 5;
    localparam int FD   = 4;
    localparam int CNTW = $clog2(FD) + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            key_flag;
    logic [KW-1:0]   key_value;
    logic            evt_valid;
    logic            evt_ready;
    logic [KW-1:0]   evt_key;
    logic            evt_double;
    logic [CNTW-1:0] evt_count;
    logic            overflow;

    key_event_queue #(
        .KEY_WIDTH (KW),
        .DOUBLE_WIN(DW),
        .CNT_W     (CW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_flag  (key_flag),
        .key_value (key_value),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_double(evt_double),
        .evt_count (evt_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KW-1:0] key;
        logic          dbl;
    } evt_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    evt_t          q[$];
    bit            pend_v   = 1'b0;
    logic [KW-1:0] pend_k   = '0;
    int            pend_c   = 0;
    bit            ovf_exp  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        check("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
        check("evt_count", 32'(evt_count), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(ovf_exp));
        if (q.size() != 0) begin
            check("evt_key", 32'(evt_key), 32'(q[0].key));
            check("evt_double", 32'(evt_double), 32'(q[0].dbl));
        end
    endtask

    // One clock cycle: check state, apply inputs, advance the reference model.
    task automatic step(input logic f, input logic [KW-1:0] v, input logic r);
        bit   strobe;
        bit   pop;
        bit   full;
        bit   has_push;
        evt_t e;
        @(negedge clk);
        compare_outputs();
        key_flag  = f;
        key_value = v;
        evt_ready = r;

        strobe   = f && (v != '0);
        pop      = r && (q.size() != 0);
        full     = (q.size() == FD);
        has_push = 1'b0;
        e        = '0;
        if (strobe && pend_v && (cyc - pend_c) <= DW) begin
            has_push = 1'b1;
            e.key    = pend_k;
            e.dbl    = (v == pend_k);
            if (v == pend_k) begin
                pend_v = 1'b0;
            end else begin
                pend_k = v;
                pend_c = cyc;
            end
        end else if (strobe) begin
            pend_v = 1'b1;
            pend_k = v;
            pend_c = cyc;
        end else if (pend_v && (cyc - pend_c) == DW) begin
            has_push = 1'b1;
            e.key    = pend_k;
            e.dbl    = 1'b0;
            pend_v   = 1'b0;
        end
        ovf_exp = has_push && full && !pop;
        if (pop) void'(q.pop_front());
        if (has_push && !(full && !pop)) q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, '0, r);
    endtask

    task automatic press_double(input logic [KW-1:0] v, input logic r1, input logic r2);
        step(1'b1, v, r1);
        step(1'b1, v, r2);
    endtask

    initial begin
        rst_n     = 1'b0;
        key_flag  = 1'b0;
        key_value = '0;
        evt_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(evt_valid), 32'd0);
        check("reset_count", 32'(evt_count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_key", 32'(evt_key), 32'd0);
        rst_n = 1'b1;

        // Single press, draining as it appears
        step(1'b1, 2'b01, 1'b1);
        idle(DW + 4, 1'b1);

        // Second press exactly at the end of the window is still a double
        step(1'b1, 2'b10, 1'b1);
        idle(DW - 1, 1'b1);
        step(1'b1, 2'b10, 1'b1);
        idle(4, 1'b1);

        // One cycle too late: single, then a fresh single
        step(1'b1, 2'b10, 1'b1);
        idle(DW, 1'b1);
        step(1'b1, 2'b10, 1'b1);
        idle(DW + 4, 1'b1);

        // Key change restarts the window
        step(1'b1, 2'b01, 1'b1);
        idle(4, 1'b1);
        step(1'b1, 2'b10, 1'b1);
        idle(DW + 4, 1'b1);

        // Flag with zero value is ignored
        step(1'b1, 2'b11, 1'b1);
        step(1'b1, 2'b00, 1'b1);
        step(1'b1, 2'b11, 1'b1);
        idle(3, 1'b1);

        // Overflow: five doubles with no consumer
        press_double(2'b01, 1'b0, 1'b0);
        press_double(2'b10, 1'b0, 1'b0);
        press_double(2'b11, 1'b0, 1'b0);
        press_double(2'b01, 1'b0, 1'b0);
        press_double(2'b10, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("ovf_count_full", 32'(evt_count), 32'd4);
        idle(8, 1'b1);

        // Fifth push coincides with a pop: accepted, no overflow
        press_double(2'b11, 1'b0, 1'b0);
        press_double(2'b01, 1'b0, 1'b0);
        press_double(2'b10, 1'b0, 1'b0);
        press_double(2'b11, 1'b0, 1'b0);
        press_double(2'b01, 1'b0, 1'b1);
        idle(2, 1'b0);
        check("ovf_count_pop", 32'(evt_count), 32'd4);
        idle(8, 1'b1);

        // Drain across pointer wrap while popping every other cycle
        for (int i = 0; i < 6; i++) begin
            step(1'b1, KW'(i % 3 + 1), 1'b0);
            step(1'b1, KW'(i % 3 + 1), 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b0);
            step(1'b0, '0, 1'b1);
        end

        // Asynchronous reset mid-WAIT with two events queued
        press_double(2'b01, 1'b0, 1'b0);
        press_double(2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        idle(3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(evt_valid), 32'd0);
        check("midrst_count", 32'(evt_count), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        q.delete();
        pend_v  = 1'b0;
        ovf_exp = 1'b0;
        key_flag = 1'b0;
        key_value = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2 * DW, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'(($urandom % 4) == 0), KW'($urandom_range(0, 3)), 1'($urandom % 2));
        end
        idle(DW + 8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
